image_stream_loader: RTL and testbench
======================================

Name: image_stream_loader

Overview:
- Synthesizable pixel source that replaces the hand-written image feeder in front of mainController.
- An N×N frame of pixelWidth-bit pixels is loaded into an internal buffer through a load port. It is then streamed to the downstream write port (we/data_in), one pixel every PACE cycles.
- Supports downstream backpressure, multi-frame repeat, and a programmable drain window that gives the kernel pipeline time to finish before done is raised.

Parameters:
- N, 8, image side length; frame = N*N pixels
- pixelWidth, 8, bits per pixel
- bitSize, $clog2(N*N), pixel index width (derived, do not set manually)
- PACE, 2, cycles between pixel issue opportunities (≥1); default matches the every-other-clock feed
- DRAIN_CYCLES, 576, cycles to wait after the last pixel of the last frame before done (≥0)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ld_en  in  1  buffer write strobe
- ld_addr  in  bitSize  buffer write address (row-major, 0..N*N-1)
- ld_data  in  pixelWidth  buffer write data
- start  in  1  single-cycle start request
- frames  in  8  number of frames to stream, latched at start; 0 is treated as 1
- ready  in  1  downstream can accept a pixel this cycle
- we  out  1  pixel valid to downstream (one-cycle pulse per pixel)
- data_out  out  pixelWidth  pixel value, valid when we=1
- pix_idx  out  bitSize  index of the pixel on data_out
- frame_done  out  1  one-cycle pulse coincident with the last pixel of each frame
- busy  out  1  high in STREAM and DRAIN
- done  out  1  high in DONE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - we, data_out, pix_idx, frame_done, busy and done are all 0.
  - Internal counters are cleared. Buffer contents are not reset.
- Reset asserted mid-stream aborts immediately; no further we pulses occur.
- All outputs are registered.
- States are IDLE, STREAM, DRAIN and DONE.
- Load:
  - ld_en=1 in IDLE or DONE writes buf[ld_addr]=ld_data at the clock edge.
  - ld_en is ignored in STREAM and DRAIN, so the buffer is frozen while busy.
  - A write is visible to reads from the next cycle onward.
- IDLE → STREAM:
  - On start=1, latch frames (0→1) into frm_left, set idx=0 and load pace_cnt=PACE-1.
  - When ld_en and start are asserted in the same cycle, the write completes and streaming starts; the written value is streamed.
- STREAM pacing:
  - pace_cnt decrements each cycle until it reaches 0.
  - Issue point = pace_cnt==0.
  - If ready=1 at the issue point, the next cycle shows we=1, data_out=buf[idx] and pix_idx=idx. idx then increments and pace_cnt reloads PACE-1.
  - If ready=0 at the issue point, pace_cnt holds at 0 and no pixel is issued. The same idx is retried every cycle until ready=1. No pixel is ever dropped or duplicated.
- Latency: start at cycle t gives the first we at cycle t+PACE when ready stays high. Pixel spacing is exactly PACE cycles under constant ready.
- End of frame:
  - The beat with pix_idx=N*N-1 also asserts frame_done.
  - idx wraps to 0 and frm_left decrements.
  - If frm_left was >1, stay in STREAM; pacing continues seamlessly, so spacing is unchanged across the frame boundary.
  - Otherwise go to DRAIN with drain_cnt=DRAIN_CYCLES.
- DRAIN:
  - drain_cnt decrements each cycle.
  - When it reaches 0, go to DONE. With DRAIN_CYCLES=0, DONE follows the cycle after the last beat.
  - busy stays high throughout DRAIN.
- DONE:
  - done is held at 1 and busy is 0.
  - start=1 restarts as from IDLE: done drops next cycle and busy rises.
  - Loading is permitted in DONE.
- start while busy is ignored.
- ready has no effect outside STREAM.
- Counter widths:
  - pace_cnt is $clog2(PACE)+1 bits.
  - drain_cnt is $clog2(DRAIN_CYCLES+1)+1 bits.
  - Index arithmetic wraps modulo N*N (power-of-two N is not required; wrap is by explicit compare).

Test Plan:
- Load buf[k]=k for k=0..63, frames=1, PACE=2, ready=1, pulse start at t → we at t+2, t+4, …, t+128 with data_out=0..63. frame_done occurs only with pix_idx=63; busy falls and done rises at t+128+577.
- Same load with ready low for 5 cycles around pixel 10 → pixel 10 is issued once, on the first issue point with ready=1. No index is skipped or repeated, and all 64 values arrive in order.
- frames=3, PACE=1, DRAIN_CYCLES=0 → 192 consecutive we pulses with pix_idx cycling 0..63 three times, three frame_done pulses, then done. frames=0 behaves exactly like frames=1.
- ld_en with ld_addr=5, ld_data=0xAA during STREAM → buffer is unchanged and pixel 5 streams its original value. The same write in the same cycle as start in IDLE → pixel 5 streams 0xAA.
- Start in DONE with new frames=2 → done clears the next cycle and a full second run completes. A start pulse during DRAIN has no effect.
- rst_n low for one cycle mid-STREAM at pixel 30 → all outputs read 0 immediately and the state is IDLE. No we occurs until a new start, and the next run begins at pix_idx=0.

Source files
------------

// File: rtl/image_stream_loader.sv
// Pixel source for the kernel front end. A frame buffer is loaded through the
// load port, then streamed to the write port with pacing, backpressure, frame repeat and a drain window.
module image_stream_loader #(
    parameter int N            = 8,
    parameter int pixelWidth   = 8,
    parameter int bitSize      = $clog2(N*N),
    parameter int PACE         = 2,
    parameter int DRAIN_CYCLES = 576
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_en,
    input  logic [bitSize-1:0]    ld_addr,
    input  logic [pixelWidth-1:0] ld_data,
    input  logic                  start,
    input  logic [7:0]            frames,
    input  logic                  ready,
    output logic                  we,
    output logic [pixelWidth-1:0] data_out,
    output logic [bitSize-1:0]    pix_idx,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  done
);

    // state  | meaning
    // IDLE   | waiting for start, buffer writable
    // STREAM | issuing one pixel per PACE cycles while ready allows
    // DRAIN  | last pixel sent, counting down the drain window
    // DONE   | run complete, done held, buffer writable, start restarts
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int FRAME = N * N;
    localparam int PW    = $clog2(PACE) + 1;
    localparam int DW    = $clog2(DRAIN_CYCLES + 1) + 1;

    localparam logic [PW-1:0]      PACE_RELOAD = PW'(PACE - 1);
    localparam logic [DW-1:0]      DRAIN_LOAD  = DW'(DRAIN_CYCLES);
    localparam logic [bitSize-1:0] LAST_IDX    = bitSize'(FRAME - 1);

    state_t                  state_q;
    logic [bitSize-1:0]      idx_q;
    logic [PW-1:0]           pace_q;
    logic [DW-1:0]           drain_q;
    logic [7:0]              frm_left_q;
    logic                    we_q;
    logic [pixelWidth-1:0]   data_q;
    logic [bitSize-1:0]      pix_idx_q;
    logic                    frame_done_q;
    logic                    busy_q;
    logic                    done_q;

    logic [pixelWidth-1:0]   mem_q [FRAME];

    logic [bitSize-1:0]      idx_d;
    logic [7:0]              frm_init_d;
    logic                    load_d;

    // Wrap by explicit compare so non-power-of-two frames index correctly.
    always_comb begin
        idx_d      = (idx_q == LAST_IDX) ? '0 : idx_q + bitSize'(1);
        frm_init_d = (frames == 8'd0) ? 8'd1 : frames;
        load_d     = ld_en
                     && ((state_q == S_IDLE) || (state_q == S_DONE))
                     && (int'(ld_addr) < FRAME);
    end

    // Buffer contents survive reset; it is only frozen while busy.
    always_ff @(posedge clk) begin
        if (load_d) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pace_q       <= '0;
            drain_q      <= '0;
            frm_left_q   <= '0;
            we_q         <= 1'b0;
            data_q       <= '0;
            pix_idx_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_STREAM;
                        frm_left_q <= frm_init_d;
                        idx_q      <= '0;
                        pace_q     <= PACE_RELOAD;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (pace_q != '0) begin
                        pace_q <= pace_q - PW'(1);
                    end else if (ready) begin
                        we_q      <= 1'b1;
                        data_q    <= mem_q[idx_q];
                        pix_idx_q <= idx_q;
                        pace_q    <= PACE_RELOAD;
                        idx_q     <= idx_d;
                        if (idx_q == LAST_IDX) begin
                            frame_done_q <= 1'b1;
                            frm_left_q   <= frm_left_q - 8'd1;
                            if (frm_left_q <= 8'd1) begin
                                state_q <= S_DRAIN;
                                drain_q <= DRAIN_LOAD;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign we         = we_q;
    assign data_out   = data_q;
    assign pix_idx    = pix_idx_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed bench for image_stream_loader: a default-parameter instance (PACE=2,
// long drain) and a fast instance (PACE=1, no drain), checked against a beat scoreboard.
module tb_image_stream_loader;

    localparam int PACE_A  = 2;
    localparam int DRAIN_A = 576;
    localparam int PACE_B  = 1;

    typedef struct packed {
        logic [7:0] data;
        logic [5:0] idx;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_en = 1'b0;
    logic [5:0] ld_addr = '0;
    logic [7:0] ld_data = '0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] frames = 8'd1;
    logic       ready = 1'b1;

    logic       we_a, fd_a, busy_a, done_a;
    logic [7:0] data_a;
    logic [5:0] idx_a;
    logic       we_b, fd_b, busy_b, done_b;
    logic [7:0] data_b;
    logic [5:0] idx_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic [7:0] model_a [64];
    logic [7:0] model_b [64];

    int a_first = -1, a_last = -1, a_beats = 0, a_space_en = 1;
    int b_first = -1, b_last = -1, b_beats = 0, b_fd_cnt = 0;
    int a_beat_cyc [64];

    image_stream_loader #(.N(8), .pixelWidth(8), .PACE(PACE_A), .DRAIN_CYCLES(DRAIN_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start_a), .frames(frames), .ready(ready),
        .we(we_a), .data_out(data_a), .pix_idx(idx_a), .frame_done(fd_a),
        .busy(busy_a), .done(done_a)
    );

    image_stream_loader #(.N(8), .pixelWidth(8), .PACE(PACE_B), .DRAIN_CYCLES(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start_b), .frames(frames), .ready(ready),
        .we(we_b), .data_out(data_b), .pix_idx(idx_b), .frame_done(fd_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (we_a) begin
                chk("a_we_expected", 32'(qa.size() > 0), 1);
                if (qa.size() > 0) begin
                    ea = qa.pop_front();
                    chk("a_data", data_a, ea.data);
                    chk("a_idx", idx_a, ea.idx);
                    chk("a_frame_done", fd_a, ea.fd);
                end
                if (a_first < 0) a_first = cyc;
                else if (a_space_en != 0) chk("a_spacing", cyc - a_last, PACE_A);
                a_last = cyc;
                a_beat_cyc[idx_a] = cyc;
                a_beats++;
            end else begin
                chk("a_fd_without_we", fd_a, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (we_b) begin
                chk("b_we_expected", 32'(qb.size() > 0), 1);
                if (qb.size() > 0) begin
                    eb = qb.pop_front();
                    chk("b_data", data_b, eb.data);
                    chk("b_idx", idx_b, eb.idx);
                    chk("b_frame_done", fd_b, eb.fd);
                end
                if (b_first < 0) b_first = cyc;
                else chk("b_spacing", cyc - b_last, PACE_B);
                b_last = cyc;
                b_beats++;
                if (fd_b) b_fd_cnt++;
            end
        end
    end

    task automatic push_a(input int nfr);
        for (int f = 0; f < nfr; f++)
            for (int k = 0; k < 64; k++)
                qa.push_back('{data: model_a[k], idx: 6'(k), fd: (k == 63)});
        a_first = -1;
        a_beats = 0;
    endtask

    task automatic push_b(input int nfr);
        for (int f = 0; f < nfr; f++)
            for (int k = 0; k < 64; k++)
                qb.push_back('{data: model_b[k], idx: 6'(k), fd: (k == 63)});
        b_first  = -1;
        b_beats  = 0;
        b_fd_cnt = 0;
    endtask

    task automatic wait_done_a(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_a) begin
                dc = cyc;
                break;
            end
        end
        chk("a_done_reached", 32'(dc >= 0), 1);
    endtask

    task automatic wait_done_b(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_b) begin
                dc = cyc;
                break;
            end
        end
        chk("b_done_reached", 32'(dc >= 0), 1);
    endtask

    initial begin
        int t, dc, t9, seen;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_we", {we_a, we_b}, 0);
        chk("rst_data", {data_a, data_b}, 0);
        chk("rst_idx", {idx_a, idx_b}, 0);
        chk("rst_fd", {fd_a, fd_b}, 0);
        chk("rst_busy", {busy_a, busy_b}, 0);
        chk("rst_done", {done_a, done_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 64; k++) begin
            ld_en = 1'b1; ld_addr = 6'(k); ld_data = 8'(k);
            model_a[k] = 8'(k); model_b[k] = 8'(k);
            @(negedge clk);
        end
        ld_en = 1'b0;

        // Single frame, PACE=2, full drain
        frames = 8'd1; ready = 1'b1;
        push_a(1);
        start_a = 1'b1; t = cyc + 1;
        @(negedge clk); start_a = 1'b0;
        chk("t1_busy_after_start", busy_a, 1);
        wait_done_a(1000, dc);
        chk("t1_first_we_cyc", a_first, t + 2);
        chk("t1_last_we_cyc", a_last, t + 128);
        chk("t1_done_cyc", dc, t + 128 + 577);
        chk("t1_busy_at_done", busy_a, 0);
        chk("t1_beats", a_beats, 64);

        // Backpressure around pixel 10
        push_a(1);
        a_space_en = 0;
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && seen == 0; i++) begin
            @(negedge clk);
            if (we_a && idx_a == 6'd9) seen = 1;
        end
        chk("t2_saw_pixel9", seen, 1);
        t9 = cyc;
        ready = 1'b0;
        repeat (5) @(negedge clk);
        ready = 1'b1;
        wait_done_a(1000, dc);
        chk("t2_pix10_cyc", a_beat_cyc[10], t9 + 6);
        chk("t2_pix11_cyc", a_beat_cyc[11], t9 + 8);
        chk("t2_beats", a_beats, 64);
        a_space_en = 1;

        // Three frames back to back on the fast instance
        frames = 8'd3;
        push_b(3);
        start_b = 1'b1; t = cyc + 1;
        @(negedge clk); start_b = 1'b0;
        wait_done_b(400, dc);
        chk("t3_first_we_cyc", b_first, t + 1);
        chk("t3_beats", b_beats, 192);
        chk("t3_fd_count", b_fd_cnt, 3);
        chk("t3_done_cyc", dc, t + 193);

        // frames=0 runs as one frame
        frames = 8'd0;
        push_b(1);
        start_b = 1'b1; t = cyc + 1;
        @(negedge clk); start_b = 1'b0;
        wait_done_b(400, dc);
        chk("t3_f0_beats", b_beats, 64);
        chk("t3_f0_done_cyc", dc, t + 65);

        // Write while streaming is ignored
        frames = 8'd1;
        push_a(1); push_b(1);
        start_a = 1'b1; start_b = 1'b1;
        @(negedge clk); start_a = 1'b0; start_b = 1'b0;
        repeat (2) @(negedge clk);
        ld_en = 1'b1; ld_addr = 6'd5; ld_data = 8'hAA;
        @(negedge clk); ld_en = 1'b0;
        wait_done_b(400, dc);
        wait_done_a(1000, dc);
        chk("t4_qa_empty", qa.size(), 0);
        chk("t4_qb_empty", qb.size(), 0);

        // Restart from DONE with a same-cycle write, frames=2
        frames = 8'd2;
        ld_en = 1'b1; ld_addr = 6'd5; ld_data = 8'hAA;
        model_a[5] = 8'hAA; model_b[5] = 8'hAA;
        push_a(2);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0; ld_en = 1'b0;
        chk("t5_done_cleared", done_a, 0);
        chk("t5_busy_set", busy_a, 1);
        for (int i = 0; i < 400 && a_beats < 128; i++) @(negedge clk);
        chk("t5_beats", a_beats, 128);
        repeat (10) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        wait_done_a(1000, dc);
        chk("t5_done_cyc_ignoring_drain_start", dc, a_last + 577);
        repeat (5) @(negedge clk);
        chk("t5_done_held", done_a, 1);
        chk("t5_qa_empty", qa.size(), 0);

        // Reset mid-stream at pixel 30
        frames = 8'd1;
        push_a(1);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge clk);
            if (we_a && idx_a == 6'd30) seen = 1;
        end
        chk("t6_saw_pixel30", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_we", we_a, 0);
        chk("t6_rst_data", data_a, 0);
        chk("t6_rst_idx", idx_a, 0);
        chk("t6_rst_fd", fd_a, 0);
        chk("t6_rst_busy", busy_a, 0);
        chk("t6_rst_done", done_a, 0);
        @(negedge clk); rst_n = 1'b1;
        qa.delete();
        repeat (20) @(negedge clk);
        chk("t6_idle_busy", busy_a, 0);
        chk("t6_idle_done", done_a, 0);
        push_a(1);
        start_a = 1'b1; t = cyc + 1;
        @(negedge clk); start_a = 1'b0;
        wait_done_a(1000, dc);
        chk("t6_first_we_cyc", a_first, t + 2);
        chk("t6_beats", a_beats, 64);

        chk("end_qa_empty", qa.size(), 0);
        chk("end_qb_empty", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
